shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
Multi-cycle unsigned multiplier that consumes an adder through the AddOp interface's Injected modport. It drives lhs/rhs and samples result, and works by iterative shift-and-add. Results are the low OPERAND_WIDTH bits of the product, with wrap-around identical to a truncated integer multiply. Requests and responses use a valid/ready handshake; it sits in the ALU arith group beside the adder implementations it is paired with.

Parameters:
OPERAND_WIDTH, 32, bitwidth of operands, product and injected adder; must equal the connected AddOp OPERAND_WIDTH; minimum 2.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request operands valid
req_ready  output  1  block can accept a request
req_lhs  input  OPERAND_WIDTH  multiplicand
req_rhs  input  OPERAND_WIDTH  multiplier
resp_valid  output  1  product valid
resp_ready  input  1  consumer accepts product
resp_product  output  OPERAND_WIDTH  (req_lhs*req_rhs) mod 2^OPERAND_WIDTH
adder  interface  AddOp.Injected  OPERAND_WIDTH  injected adder; block drives lhs, rhs and reads result

Behaviour:
- Reset is asynchronous and active-high, on rst. It forces state IDLE, acc=0, mcand=0, mplier=0, count=0, resp_valid=0 and resp_product=0. req_ready is 1 once rst deasserts.
- Reset mid-operation aborts the multiply with no response; a DONE product not yet taken is discarded.
- State IDLE: req_ready=1 and resp_valid=0.
  - On an edge with req_valid=1: acc<=0, mcand<=req_lhs, mplier<=req_rhs, count<=0, go to BUSY.
- State BUSY (exactly OPERAND_WIDTH cycles): req_ready=0 and resp_valid=0.
  - Adder drive is combinational: adder.lhs=acc, adder.rhs = mplier[0] ? mcand : 0.
  - Each edge: acc<=adder.result, mcand<=mcand<<1 (MSB dropped), mplier<=mplier>>1 (zero fill), count<=count+1.
  - On the edge where count==OPERAND_WIDTH-1, go to DONE.
- State DONE: resp_valid=1, resp_product=acc, req_ready=0.
  - On an edge with resp_ready=1, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
  - resp_product is stable while resp_valid=1 and resp_ready=0.
- Latency: request accepted at edge t gives resp_valid=1 from edge t+OPERAND_WIDTH. Minimum initiation interval is OPERAND_WIDTH+2 cycles.
- Adder outside BUSY: adder.lhs and adder.rhs are driven 0; adder.result is ignored.
- Width rule: no carry out of the injected adder exists, so every sum wraps mod 2^OPERAND_WIDTH. This is intentional and matches the truncated-product definition.
- Handshake rules:
  - req_lhs and req_rhs are sampled only on the accepting edge; later changes have no effect.
  - req_valid while BUSY or DONE is ignored and is not queued.
  - resp_ready outside DONE is ignored.
- No early termination: zero or small multipliers still take the full OPERAND_WIDTH cycles, so latency is fixed.
- No X on any output after reset. The adder is treated as purely combinational (result valid in the same cycle).

Decomposition:
- Package shift_add_multiplier_pkg:
  - typedef enum state_t {IDLE, BUSY, DONE};
  - function count_width(w) = $clog2(w), used for the count register.
- No internal sub-module. The adder is external, connected through the AddOp.Injected port.
- The testbench instantiates an existing AddOp.Impl combinational adder to close the loop.

Test Plan:
- Basic multiply: req 6,7 accepted at edge t -> resp_valid rises at edge t+32, resp_product=42; resp_ready=1 returns to IDLE next edge.
- Wrap-around: req 0xFFFFFFFF,0xFFFFFFFF -> resp_product=0x00000001. Req 0x80000000,2 -> 0x00000000.
- Zeros and identity: req 0,0xDEADBEEF -> 0 after the full 32 cycles. Req 0x12345678,1 -> 0x12345678. Monitor adder.rhs: nonzero only in BUSY cycle 0.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid stays 1 and resp_product stays stable. req_valid pulses with 3,3 in that window are ignored (req_ready=0, no second result). Release -> IDLE, then a new req 3,3 -> 9.
- Reset mid-op: assert rst at BUSY cycle 15 of req 5,5 -> immediately state IDLE, resp_valid=0, adder.lhs=adder.rhs=0. After release, req 5,5 -> 25 with full latency.
- Random regression: 1000 random operand pairs with random resp_ready stalls -> every product equals (a*b) mod 2^32. Each response follows exactly 32 BUSY cycles.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types for the shift-and-add multiplier.
// State encoding and count register sizing.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int count_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/add_op.sv
// Adder operation interface shared by ALU arith blocks.
// Injected side drives operands, Impl side returns the sum.
interface AddOp #(
  parameter int OPERAND_WIDTH = 32
);

  logic [OPERAND_WIDTH-1:0] lhs;
  logic [OPERAND_WIDTH-1:0] rhs;
  logic [OPERAND_WIDTH-1:0] result;

  modport Injected (
    output lhs,
    output rhs,
    input  result
  );

  modport Impl (
    input  lhs,
    input  rhs,
    output result
  );

endinterface

// File: rtl/add_op_adder.sv
// Plain combinational adder behind AddOp.Impl.
// Sum wraps modulo 2^OPERAND_WIDTH; no carry out.
module add_op_adder (
  AddOp.Impl a
);

  assign a.result = a.lhs + a.rhs;

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier.
// Uses an injected AddOp adder; product truncated to operand width.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPERAND_WIDTH-1:0] req_lhs,
  input  logic [OPERAND_WIDTH-1:0] req_rhs,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [OPERAND_WIDTH-1:0] resp_product,
  AddOp.Injected                   adder
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = count_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    count_d      = count_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_product = '0;
    adder.lhs    = '0;
    adder.rhs    = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          acc_d    = '0;
          mcand_d  = req_lhs;
          mplier_d = req_rhs;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Fixed latency: every multiplier bit is visited, even zeros.
        adder.lhs = acc_q;
        adder.rhs = mplier_q[0] ? mcand_q : '0;
        acc_d     = adder.result;
        mcand_d   = {mcand_q[W-2:0], 1'b0};
        mplier_d  = {1'b0, mplier_q[W-1:1]};
        count_d   = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_valid   = 1'b1;
        resp_product = acc_q;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Cycle-level arithmetic model plus directed literal products.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_lhs;
  logic [31:0] req_rhs;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_product;

  int n_vec;
  int n_fail;
  int cyc;

  AddOp #(.OPERAND_WIDTH(32)) u_add ();

  add_op_adder u_impl (
    .a (u_add)
  );

  shift_add_multiplier #(
    .OPERAND_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_lhs      (req_lhs),
    .req_rhs      (req_rhs),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .adder        (u_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: an accepted request yields a*b mod 2^32 after 32 work cycles.
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [31:0] m_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_done = 0;
      m_left = 0;
    end else if (m_done) begin
      if (resp_ready) m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (req_valid) begin
      m_a    = req_lhs;
      m_b    = req_rhs;
      m_prod = req_lhs * req_rhs;
      m_busy = 1;
      m_left = 32;
    end
  end

  // Partial sums: in work cycle k the running total covers bits below k.
  always @(negedge clk) begin
    int          k;
    logic [63:0] msk;
    logic [31:0] e_lhs;
    logic [31:0] e_rhs;
    if (!rst) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy && !m_done});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_done});
      if (m_done) chk("resp_product", resp_product, m_prod);
      if (m_busy) begin
        k     = 32 - m_left;
        msk   = (64'd1 << k) - 64'd1;
        e_lhs = m_a * (m_b & msk[31:0]);
        e_rhs = m_b[k] ? (m_a << k) : 32'd0;
        chk("adder_lhs", u_add.lhs, e_lhs);
        chk("adder_rhs", u_add.rhs, e_rhs);
      end else begin
        chk("adder_lhs_idle", u_add.lhs, 32'd0);
        chk("adder_rhs_idle", u_add.rhs, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!req_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input string nm);
    int t0;
    int k;
    wait_idle();
    req_valid = 1'b1;
    req_lhs   = a;
    req_rhs   = b;
    @(posedge clk);
    #1;
    t0        = cyc;
    req_valid = 1'b0;
    req_lhs   = $urandom;
    req_rhs   = $urandom;
    k = 0;
    while (!resp_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, "_latency"}, cyc - t0, 32'd32);
    chk({nm, "_product"}, resp_product, lit);
  endtask

  // Handshake with a competing request that must not be taken.
  task automatic take();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_lhs    = 32'd3;
    req_rhs    = 32'd3;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    int          k;
    n_vec      = 0;
    n_fail     = 0;
    cyc        = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_lhs    = '0;
    req_rhs    = '0;
    resp_ready = 1'b0;

    #3;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_product", resp_product, 32'd0);
    chk("rst_adder_lhs", u_add.lhs, 32'd0);
    chk("rst_adder_rhs", u_add.rhs, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    mul(32'd6, 32'd7, 32'd42, "basic");
    take();
    chk("basic_back_idle", {31'd0, req_ready}, 32'd1);

    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "wrap_ones");
    take();
    mul(32'h8000_0000, 32'd2, 32'd0, "wrap_msb");
    take();
    mul(32'd0, 32'hDEAD_BEEF, 32'd0, "zero");
    take();
    mul(32'h1234_5678, 32'd1, 32'h1234_5678, "identity");
    take();

    mul(32'd6, 32'd7, 32'd42, "bp");
    for (int i = 0; i < 10; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_lhs   = 32'd3;
      req_rhs   = 32'd3;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_stable", resp_product, 32'd42);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    take();
    mul(32'd3, 32'd3, 32'd9, "after_bp");
    take();

    wait_idle();
    req_valid = 1'b1;
    req_lhs   = 32'd5;
    req_rhs   = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_adder_lhs", u_add.lhs, 32'd0);
    chk("midrst_adder_rhs", u_add.rhs, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mul(32'd5, 32'd5, 32'd25, "after_rst");
    take();

    for (int i = 0; i < 1000; i++) begin
      a = pick();
      b = pick();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      mul(a, b, a * b, "rand");
      k = 0;
      do begin
        r          = ($urandom_range(0, 3) == 0);
        resp_ready = r;
        @(posedge clk);
        #1;
        k++;
      end while (!r && k < 20);
      resp_ready = 1'b0;
      if (!r) take();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
